// File: rtl/fft_bitrev_port.sv
// fft_bitrev_port: host-side FFT stand-in that buffers a block, bit-reverse reorders it and serves results.
// Optional macro FFT_BITREV_CONJ_EN: conjugate (saturating) imag on inverse-direction runs.
module fft_bitrev_port #(
    parameter int unsigned Nb        = 18,
    parameter int unsigned log_depth = 10,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ctl_ready,
    input  logic                 ctl_start,
    input  logic [3:0]           ctl_log_depth,
    input  logic                 ctl_real_mode,
    input  logic                 ctl_direction,
    output logic                 ctl_done,
    output logic [3:0]           ctl_output_scaling,
    input  logic [log_depth-1:0] data_address,
    input  logic                 data_read_enable,
    output logic                 data_read_valid,
    output logic [2*Nb-1:0]      data_read_data,
    input  logic                 data_write_enable,
    input  logic [2*Nb-1:0]      data_write_data
);
    localparam int unsigned W     = 2 * Nb;
    localparam int unsigned DEPTH = 1 << log_depth;
    localparam int unsigned CW    = log_depth + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PERMUTE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_ready_d;
    logic                 w_done_d;
    logic                 w_start;
    logic                 w_host_wr;
    logic                 w_host_rd;
    logic [3:0]           w_len_clamp;
    logic [CW-1:0]        w_n;
    logic [log_depth-1:0] w_mask;

    logic                 r_ready;
    logic                 r_done;
    logic [3:0]           r_len;
    logic                 r_real;
    logic                 r_dir;
    logic [CW-1:0]        r_cnt;
    logic                 r_wr_vld;
    logic [log_depth-1:0] r_wr_addr;
    logic [W-1:0]         r_rd_a;
    logic [W-1:0]         w_b_word;
    logic [Nb-1:0]        w_imag;

    logic [W-1:0]         r_mem_a [DEPTH];
    logic [W-1:0]         r_mem_b [DEPTH];

    logic [RD_LAT-1:0]    r_pv;
    logic [W-1:0]         r_pd [RD_LAT];

    // Reverse the low len bits of i: full reversal, then drop the unused low bits.
    function automatic logic [log_depth-1:0] bitrev(input logic [log_depth-1:0] i,
                                                   input logic [3:0] len);
        logic [log_depth-1:0] rev;
        logic [3:0]           sh;
        for (int b = 0; b < int'(log_depth); b++) begin
            rev[log_depth-1-b] = i[b];
        end
        sh = 4'(log_depth) - len;
        return rev >> sh;
    endfunction

    assign w_start   = (r_state == S_IDLE) && ctl_start;
    assign w_host_wr = data_write_enable && (r_state != S_PERMUTE);
    assign w_host_rd = data_read_enable && (r_state != S_PERMUTE);
    assign w_n       = CW'(1) << r_len;
    assign w_mask    = log_depth'(w_n - CW'(1));

    always_comb begin
        w_len_clamp = ctl_log_depth;
        if (ctl_log_depth == 4'd0) begin
            w_len_clamp = 4'd1;
        end else if (ctl_log_depth > 4'(log_depth)) begin
            w_len_clamp = 4'(log_depth);
        end
    end

    // Next state and registered-output targets.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (ctl_start) w_next = S_PERMUTE;
            S_PERMUTE: if (r_cnt == w_n + CW'(1)) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        w_ready_d = (w_next != S_PERMUTE);
        w_done_d  = (w_next == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_len     <= 4'(log_depth);
            r_real    <= 1'b0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_d;
            r_done  <= w_done_d;
            if (w_start) begin
                r_len  <= w_len_clamp;
                r_real <= ctl_real_mode;
                r_dir  <= ctl_direction;
                r_cnt  <= '0;
            end else if (r_state == S_PERMUTE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Counter runs to N+1 so the last A read has a cycle to land in B.
            r_wr_vld  <= (r_state == S_PERMUTE) && (r_cnt < w_n);
            r_wr_addr <= bitrev(r_cnt[log_depth-1:0], r_len);
        end
    end

    always_comb begin
        w_imag = r_rd_a[W-1:Nb];
`ifdef FFT_BITREV_CONJ_EN
        if (r_dir) begin
            w_imag = (r_rd_a[W-1:Nb] == {1'b1, {(Nb-1){1'b0}}}) ? {1'b0, {(Nb-1){1'b1}}}
                                                                 : -r_rd_a[W-1:Nb];
        end
`endif
        if (r_real) begin
            w_imag = '0;
        end
        w_b_word = {w_imag, r_rd_a[Nb-1:0]};
    end

`ifndef FFT_BITREV_CONJ_EN
    logic w_unused_dir;
    assign w_unused_dir = r_dir;
`endif

    // Bank storage: not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_host_wr) begin
            r_mem_a[data_address] <= data_write_data;
        end
        r_rd_a <= r_mem_a[r_cnt[log_depth-1:0]];
        if (r_wr_vld) begin
            r_mem_b[r_wr_addr] <= w_b_word;
        end
    end

    // Host read pipeline, RD_LAT stages, one read per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv <= '0;
            for (int j = 0; j < int'(RD_LAT); j++) begin
                r_pd[j] <= '0;
            end
        end else begin
            r_pv[0] <= w_host_rd;
            if (w_host_rd) begin
                r_pd[0] <= r_mem_b[data_address & w_mask];
            end
            for (int j = 1; j < int'(RD_LAT); j++) begin
                r_pv[j] <= r_pv[j-1];
                r_pd[j] <= r_pd[j-1];
            end
        end
    end

    assign ctl_ready          = r_ready;
    assign ctl_done           = r_done;
    assign ctl_output_scaling = 4'd0;
    assign data_read_valid    = r_pv[RD_LAT-1];
    assign data_read_data     = r_pd[RD_LAT-1];

endmodule
